// File: rtl/dcram_ctl_pkg.sv
// Shared encodings for the data-cache RAM access controller.
// Holds the controller state codes, bank-select codes and the full write-enable mask.
package dcram_ctl_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StWb   = 2'd2;

    localparam logic [1:0] BS_NONE = 2'b00;
    localparam logic [1:0] BS_W0   = 2'b01;
    localparam logic [1:0] BS_W1   = 2'b10;

    localparam logic [3:0] WE_FULL = 4'hF;

    function automatic logic [1:0] way_to_bs(input logic way);
        return way ? BS_W1 : BS_W0;
    endfunction

endpackage

// File: rtl/dcram_ctl_starve.sv
// Starvation bound for fill/copy-back beats.
// Counts the cycles the pipe beats a waiting engine beat; force_o grants the engine once the bound is hit.
module dcram_ctl_starve
    import dcram_ctl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req_other_i,
    input  logic beat_issued_i,
    output logic force_o
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] wait_q, wait_d;

    assign force_o = (wait_q == CntW'(MAX_WAIT));

    always_comb begin
        wait_d = wait_q;
        if (beat_issued_i) begin
            wait_d = '0;
        end else if (req_other_i && !force_o) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/dcram_ctl.sv
// Data-cache RAM controller: shares the single dcram port between the pipe, the line-fill
// engine and the victim copy-back reader, and drives the dcram pins directly.
module dcram_ctl
    import dcram_ctl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned BEATS    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_req,
    input  logic [3:0]        pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic              pipe_way,
    input  logic [63:0]       pipe_wdata,
    input  logic              pipe_hold,
    output logic              pipe_gnt,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic              fill_way,
    input  logic              fill_valid,
    input  logic [63:0]       fill_data,
    output logic              fill_ready,
    output logic              fill_done,
    input  logic              wb_start,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_way,
    output logic              wb_valid,
    output logic              wb_done,
    output logic              busy,
    output logic [63:0]       ram_data_in,
    output logic [3:0]        ram_we,
    output logic              ram_bypass,
    output logic [1:0]        ram_bank_sel,
    output logic              ram_reg_enable,
    output logic [ADDR_W-1:0] ram_addr
);

    localparam int unsigned BeatW = $clog2(BEATS);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

    logic [1:0]        state_q, state_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] line_q, line_d;
    logic              way_q, way_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_way_q, pend_way_d;
    logic              wb_vld_q, wb_done_q;
    logic              lw_valid_q, lw_way_q;
    logic [ADDR_W-1:0] lw_addr_q;

    logic engine_work, engine_issue, force_beat, fill_issue, wb_issue, last_beat, ram_rd;

    assign engine_work  = (state_q == StFill && fill_valid) || state_q == StWb;
    assign engine_issue = engine_work && (!pipe_req || force_beat);
    assign fill_ready   = state_q == StFill && (!pipe_req || force_beat);
    assign fill_issue   = fill_ready && fill_valid;
    assign wb_issue     = engine_issue && state_q == StWb;
    assign last_beat    = beat_q == LastBeat;

    assign pipe_gnt  = pipe_req && !engine_issue;
    assign fill_done = fill_issue && last_beat;
    assign wb_valid  = wb_vld_q;
    assign wb_done   = wb_done_q;
    assign busy      = state_q != StIdle || pend_q;

    dcram_ctl_starve #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk          (clk),
        .reset        (reset),
        .req_other_i  (engine_work && pipe_req),
        .beat_issued_i(engine_issue),
        .force_o      (force_beat)
    );

    always_comb begin
        ram_addr     = pipe_addr;
        ram_data_in  = pipe_wdata;
        ram_we       = '0;
        ram_bank_sel = BS_NONE;
        if (engine_issue) begin
            ram_addr     = line_q | ADDR_W'(beat_q);
            ram_bank_sel = way_to_bs(way_q);
            if (fill_issue) begin
                ram_we      = WE_FULL;
                ram_data_in = fill_data;
            end
        end else if (pipe_gnt) begin
            ram_we       = pipe_we;
            ram_bank_sel = way_to_bs(pipe_way);
        end
    end

    assign ram_rd     = ram_bank_sel != BS_NONE && ram_we == 4'h0;
    assign ram_bypass = ram_rd && lw_valid_q && lw_addr_q == ram_addr
                        && lw_way_q == ram_bank_sel[1];
    // Copy-back data must land in the output register even while the pipe is stalled.
    assign ram_reg_enable = !pipe_hold || wb_vld_q;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_d      = line_q;
        way_d       = way_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_way_d  = pend_way_q;
        case (state_q)
            StIdle: begin
                if (wb_start) begin
                    state_d = StWb;
                    line_d  = wb_addr;
                    way_d   = wb_way;
                    beat_d  = '0;
                    // Victim is read out before the fill overwrites it.
                    if (fill_start) begin
                        pend_d      = 1'b1;
                        pend_addr_d = fill_addr;
                        pend_way_d  = fill_way;
                    end
                end else if (fill_start) begin
                    state_d = StFill;
                    line_d  = fill_addr;
                    way_d   = fill_way;
                    beat_d  = '0;
                end
            end
            StFill: begin
                if (fill_issue) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) state_d = StIdle;
                end
            end
            StWb: begin
                if (wb_issue) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        if (pend_q) begin
                            state_d = StFill;
                            line_d  = pend_addr_q;
                            way_d   = pend_way_q;
                            pend_d  = 1'b0;
                            beat_d  = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            line_q      <= '0;
            way_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_way_q  <= 1'b0;
            wb_vld_q    <= 1'b0;
            wb_done_q   <= 1'b0;
            lw_valid_q  <= 1'b0;
            lw_addr_q   <= '0;
            lw_way_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            way_q       <= way_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_way_q  <= pend_way_d;
            wb_vld_q    <= wb_issue;
            wb_done_q   <= wb_issue && last_beat;
            lw_valid_q  <= ram_bank_sel != BS_NONE && ram_we != 4'h0;
            lw_addr_q   <= ram_addr;
            lw_way_q    <= ram_bank_sel[1];
        end
    end

endmodule

// File: tb/tb_dcram_ctl.sv
// Self-checking bench for dcram_ctl: a dcram model plus scoreboards of expected RAM
// accesses and expected copy-back data.
module tb_dcram_ctl;

    typedef struct packed {
        logic [11:0] addr;
        logic [1:0]  bank;
        logic [3:0]  we;
        logic [63:0] data;
        logic        byp;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_req, pipe_way, pipe_hold, pipe_gnt;
    logic [3:0]  pipe_we;
    logic [11:0] pipe_addr;
    logic [63:0] pipe_wdata;
    logic        fill_start, fill_way, fill_valid, fill_ready, fill_done;
    logic [11:0] fill_addr;
    logic [63:0] fill_data;
    logic        wb_start, wb_way, wb_valid, wb_done, busy;
    logic [11:0] wb_addr;
    logic [63:0] ram_data_in;
    logic [3:0]  ram_we;
    logic        ram_bypass, ram_reg_enable;
    logic [1:0]  ram_bank_sel;
    logic [11:0] ram_addr;

    int checks = 0;
    int errors = 0;
    acc_t exp_q[$];
    logic [63:0] wb_q[$];
    acc_t e;
    logic [63:0] we_exp;

    always #5 clk = ~clk;

    dcram_ctl dut (
        .clk           (clk),
        .reset         (reset),
        .pipe_req      (pipe_req),
        .pipe_we       (pipe_we),
        .pipe_addr     (pipe_addr),
        .pipe_way      (pipe_way),
        .pipe_wdata    (pipe_wdata),
        .pipe_hold     (pipe_hold),
        .pipe_gnt      (pipe_gnt),
        .fill_start    (fill_start),
        .fill_addr     (fill_addr),
        .fill_way      (fill_way),
        .fill_valid    (fill_valid),
        .fill_data     (fill_data),
        .fill_ready    (fill_ready),
        .fill_done     (fill_done),
        .wb_start      (wb_start),
        .wb_addr       (wb_addr),
        .wb_way        (wb_way),
        .wb_valid      (wb_valid),
        .wb_done       (wb_done),
        .busy          (busy),
        .ram_data_in   (ram_data_in),
        .ram_we        (ram_we),
        .ram_bypass    (ram_bypass),
        .ram_bank_sel  (ram_bank_sel),
        .ram_reg_enable(ram_reg_enable),
        .ram_addr      (ram_addr)
    );

    // dcram model: synchronous array read, output register held while reg_enable=0.
    logic [63:0] mem [0:8191];
    logic [63:0] raw_q, held_q;
    wire  [63:0] model_dout = ram_reg_enable ? raw_q : held_q;

    always @(posedge clk) begin
        if (ram_bank_sel != 2'b00) begin
            if (ram_we != 4'h0) begin
                for (int h = 0; h < 4; h++) begin
                    if (ram_we[h]) mem[{ram_bank_sel[1], ram_addr}][16*h +: 16] <= ram_data_in[16*h +: 16];
                end
            end else begin
                raw_q <= mem[{ram_bank_sel[1], ram_addr}];
            end
        end
        if (ram_reg_enable) held_q <= model_dout;
    end

    // Scoreboard consumers: every issued access and every copy-back beat.
    always @(negedge clk) begin
        if (ram_bank_sel != 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL access: unexpected addr=%h bank=%b we=%h", ram_addr, ram_bank_sel, ram_we);
            end else begin
                e = exp_q.pop_front();
                if (ram_addr !== e.addr || ram_bank_sel !== e.bank || ram_we !== e.we ||
                    ram_bypass !== e.byp || (e.we != 4'h0 && ram_data_in !== e.data)) begin
                    errors++;
                    $display("FAIL access: got addr=%h bank=%b we=%h byp=%b data=%h want addr=%h bank=%b we=%h byp=%b data=%h",
                             ram_addr, ram_bank_sel, ram_we, ram_bypass, ram_data_in,
                             e.addr, e.bank, e.we, e.byp, e.data);
                end
            end
        end
        if (wb_valid) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_data: unexpected wb_valid, data=%h", model_dout);
            end else begin
                we_exp = wb_q.pop_front();
                if (model_dout !== we_exp) begin
                    errors++;
                    $display("FAIL wb_data: got %h want %h", model_dout, we_exp);
                end
            end
        end
        if (busy && (fill_start || wb_start)) begin
            errors++;
            $display("FAIL protocol: start pulse while busy");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_acc(input logic [11:0] a, input logic [1:0] b, input logic [3:0] w,
                              input logic [63:0] d, input logic y);
        acc_t t;
        t.addr = a; t.bank = b; t.we = w; t.data = d; t.byp = y;
        exp_q.push_back(t);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pipe_req = 0; pipe_we = 0; pipe_addr = 0; pipe_way = 0; pipe_wdata = 0; pipe_hold = 0;
        fill_start = 0; fill_addr = 0; fill_way = 0; fill_valid = 0; fill_data = 0;
        wb_start = 0; wb_addr = 0; wb_way = 0;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({pipe_gnt, fill_ready, fill_done, wb_valid, wb_done, busy, ram_bypass, ram_reg_enable,
             ram_bank_sel, ram_we} !== 14'b00000001_00_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000001000000",
                     {pipe_gnt, fill_ready, fill_done, wb_valid, wb_done, busy, ram_bypass,
                      ram_reg_enable, ram_bank_sel, ram_we});
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_fill_bypass();
        fill_start = 1; fill_addr = 12'h040; fill_way = 1;
        expect_acc(12'h040, 2'b10, 4'hF, 64'h1111_2222_3333_4444, 0);
        expect_acc(12'h041, 2'b10, 4'hF, 64'h5555_6666_7777_8888, 0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL fill_start_busy: got %b want 0", busy); end
        step();
        fill_start = 0; fill_valid = 1; fill_data = 64'h1111_2222_3333_4444;
        @(negedge clk);
        checks++;
        if ({fill_ready, busy, fill_done} !== 3'b110) begin
            errors++; $display("FAIL fill_beat0: got rdy/busy/done=%b want 110", {fill_ready, busy, fill_done});
        end
        step();
        fill_data = 64'h5555_6666_7777_8888;
        @(negedge clk);
        checks++;
        if (fill_done !== 1'b1) begin errors++; $display("FAIL fill_done: got %b want 1", fill_done); end
        step();
        // Load of the row just filled, then store/load pairs exercising way and address match.
        fill_valid = 0; pipe_req = 1; pipe_we = 0; pipe_addr = 12'h041; pipe_way = 1;
        expect_acc(12'h041, 2'b10, 4'h0, 64'h0, 1);
        @(negedge clk);
        checks++;
        if ({pipe_gnt, busy, fill_done} !== 3'b100) begin
            errors++; $display("FAIL pipe_after_fill: got gnt/busy/done=%b want 100", {pipe_gnt, busy, fill_done});
        end
        step();
        pipe_we = 4'b0101; pipe_addr = 12'h010; pipe_way = 0; pipe_wdata = 64'hDEAD_BEEF_0123_4567;
        expect_acc(12'h010, 2'b01, 4'b0101, 64'hDEAD_BEEF_0123_4567, 0);
        step();
        pipe_we = 0; pipe_way = 1;
        expect_acc(12'h010, 2'b10, 4'h0, 64'h0, 0);
        step();
        pipe_we = 4'hF; pipe_addr = 12'h011; pipe_way = 0; pipe_wdata = 64'hCAFE_F00D_AAAA_5555;
        expect_acc(12'h011, 2'b01, 4'hF, 64'hCAFE_F00D_AAAA_5555, 0);
        step();
        pipe_we = 0;
        expect_acc(12'h011, 2'b01, 4'h0, 64'h0, 1);
        step();
        expect_acc(12'h011, 2'b01, 4'h0, 64'h0, 0);
        step();
        pipe_req = 0;
    endtask

    task automatic test_starve();
        logic exp_gnt;
        logic [63:0] s;
        fill_start = 1; fill_addr = 12'h100; fill_way = 0;
        @(negedge clk);
        step();
        fill_start = 0; fill_valid = 1; pipe_req = 1; pipe_we = 0; pipe_way = 0;
        for (int i = 0; i < 10; i++) begin
            s = (i < 5) ? 64'hA5A5_0000_0000_0001 : 64'hA5A5_0000_0000_0002;
            fill_data = s;
            pipe_addr = 12'h200 + 12'(i);
            exp_gnt = (i % 5) != 4;
            if (exp_gnt) expect_acc(12'h200 + 12'(i), 2'b01, 4'h0, 64'h0, 0);
            else expect_acc(12'h100 + 12'(i / 5), 2'b01, 4'hF, s, 0);
            @(negedge clk);
            checks++;
            if (pipe_gnt !== exp_gnt || fill_done !== (i == 9)) begin
                errors++;
                $display("FAIL starve_cycle%0d: got gnt=%b done=%b want gnt=%b done=%b",
                         i, pipe_gnt, fill_done, exp_gnt, (i == 9));
            end
            step();
        end
        pipe_req = 0; fill_valid = 0;
    endtask

    task automatic test_wb_then_fill();
        fill_start = 1; fill_addr = 12'h080; fill_way = 0;
        expect_acc(12'h080, 2'b01, 4'hF, 64'h0A0A_0A0A_0A0A_0A00, 0);
        expect_acc(12'h081, 2'b01, 4'hF, 64'h0A0A_0A0A_0A0A_0A01, 0);
        @(negedge clk);
        step();
        fill_start = 0; fill_valid = 1; fill_data = 64'h0A0A_0A0A_0A0A_0A00;
        step();
        fill_data = 64'h0A0A_0A0A_0A0A_0A01;
        step();
        fill_valid = 0;
        wb_start = 1; wb_addr = 12'h080; wb_way = 0; fill_start = 1; fill_addr = 12'h080; fill_way = 0;
        expect_acc(12'h080, 2'b01, 4'h0, 64'h0, 0);
        expect_acc(12'h081, 2'b01, 4'h0, 64'h0, 0);
        expect_acc(12'h080, 2'b01, 4'hF, 64'h0B0B_0B0B_0B0B_0B00, 0);
        expect_acc(12'h081, 2'b01, 4'hF, 64'h0B0B_0B0B_0B0B_0B01, 0);
        wb_q.push_back(64'h0A0A_0A0A_0A0A_0A00);
        wb_q.push_back(64'h0A0A_0A0A_0A0A_0A01);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wbf_start_busy: got %b want 0", busy); end
        step();
        wb_start = 0; fill_start = 0; fill_valid = 1; fill_data = 64'h0B0B_0B0B_0B0B_0B00;
        @(negedge clk);
        checks++;
        if ({busy, wb_valid, fill_ready} !== 3'b100) begin
            errors++; $display("FAIL wbf_t1: got busy/wbv/rdy=%b want 100", {busy, wb_valid, fill_ready});
        end
        step();
        @(negedge clk);
        checks++;
        if ({busy, wb_valid, wb_done, fill_ready} !== 4'b1100) begin
            errors++; $display("FAIL wbf_t2: got busy/wbv/wbd/rdy=%b want 1100", {busy, wb_valid, wb_done, fill_ready});
        end
        step();
        @(negedge clk);
        checks++;
        if ({busy, wb_valid, wb_done, fill_ready} !== 4'b1111) begin
            errors++; $display("FAIL wbf_t3: got busy/wbv/wbd/rdy=%b want 1111", {busy, wb_valid, wb_done, fill_ready});
        end
        step();
        fill_data = 64'h0B0B_0B0B_0B0B_0B01;
        @(negedge clk);
        checks++;
        if ({busy, fill_done, wb_valid} !== 3'b110) begin
            errors++; $display("FAIL wbf_t4: got busy/done/wbv=%b want 110", {busy, fill_done, wb_valid});
        end
        step();
        fill_valid = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wbf_end_busy: got %b want 0", busy); end
        step();
    endtask

    task automatic test_wb_hold();
        logic [3:0] exp_re;
        exp_re = 4'b0110;
        pipe_hold = 1; wb_start = 1; wb_addr = 12'h100; wb_way = 0;
        expect_acc(12'h100, 2'b01, 4'h0, 64'h0, 0);
        expect_acc(12'h101, 2'b01, 4'h0, 64'h0, 0);
        wb_q.push_back(64'hA5A5_0000_0000_0001);
        wb_q.push_back(64'hA5A5_0000_0000_0002);
        @(negedge clk);
        step();
        wb_start = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ram_reg_enable !== exp_re[i] || wb_valid !== exp_re[i]) begin
                errors++;
                $display("FAIL wb_hold_cycle%0d: got reg_en=%b wbv=%b want %b", i, ram_reg_enable, wb_valid, exp_re[i]);
            end
            step();
        end
        pipe_hold = 0;
    endtask

    task automatic test_reset_mid_fill();
        int beats;
        int n;
        logic done;
        fill_start = 1; fill_addr = 12'h0C0; fill_way = 1;
        expect_acc(12'h0C0, 2'b10, 4'hF, 64'h0C0C_0000_0000_0000, 0);
        @(negedge clk);
        step();
        fill_start = 0; fill_valid = 1; fill_data = 64'h0C0C_0000_0000_0000;
        @(negedge clk);
        checks++;
        if (fill_ready !== 1'b1) begin errors++; $display("FAIL rst_fill_beat0: got rdy=%b want 1", fill_ready); end
        step();
        fill_valid = 0; reset = 1;
        @(negedge clk);
        checks++;
        if (fill_done !== 1'b0) begin errors++; $display("FAIL rst_no_done: got %b want 0", fill_done); end
        step();
        reset = 0; fill_valid = 1; fill_data = 64'h0C0C_FFFF_0000_0000;
        @(negedge clk);
        checks++;
        if ({pipe_gnt, fill_ready, fill_done, wb_valid, wb_done, busy, ram_bypass, ram_reg_enable,
             ram_bank_sel, ram_we} !== 14'b00000001_00_0000) begin
            errors++;
            $display("FAIL rst_mid_idle: got %b want 00000001000000",
                     {pipe_gnt, fill_ready, fill_done, wb_valid, wb_done, busy, ram_bypass,
                      ram_reg_enable, ram_bank_sel, ram_we});
        end
        step();
        fill_valid = 0; fill_start = 1;
        expect_acc(12'h0C0, 2'b10, 4'hF, 64'h0C0C_0000_0000_0002, 0);
        expect_acc(12'h0C1, 2'b10, 4'hF, 64'h0C0C_0000_0000_0003, 0);
        @(negedge clk);
        step();
        fill_start = 0; fill_valid = 1;
        beats = 0; n = 0; done = 0;
        while (!done && n < 8) begin
            fill_data = (beats == 0) ? 64'h0C0C_0000_0000_0002 : 64'h0C0C_0000_0000_0003;
            @(negedge clk);
            if (fill_ready) beats++;
            if (fill_done) done = 1;
            n++;
            step();
        end
        fill_valid = 0;
        checks++;
        if (!done || beats != 2) begin
            errors++; $display("FAIL rst_refill: got done=%b beats=%0d want done=1 beats=2", done, beats);
        end
        step();
    endtask

    task automatic test_drain();
        checks++;
        if (exp_q.size() != 0 || wb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d accesses and %0d wb beats outstanding want 0 and 0",
                     exp_q.size(), wb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill_bypass();
        test_starve();
        test_wb_then_fill();
        test_wb_hold();
        test_reset_mid_fill();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
